// File: rtl/params_pkg.sv
// Shared parameters and types for the ff_sync_bus synchronizer family.
//   edge_mode_t        : which level transitions qualify for a pulse
//   SIM_HALF_PERIOD_NS : half clock period used by simulation benches
//   edge_hit()         : transition qualifier shared by all channels
package params_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_t;

  localparam int SIM_HALF_PERIOD_NS = 5;

  // True when the prev -> nxt level step matches the requested edge mode.
  function automatic logic edge_hit(input edge_mode_t mode, input logic prev,
                                    input logic nxt);
    case (mode)
      EDGE_RISE: return ~prev & nxt;
      EDGE_FALL: return prev & ~nxt;
      default:   return prev ^ nxt;
    endcase
  endfunction

endpackage

// File: rtl/ff_sync_debounce.sv
// Single-channel debounce filter placed after a synchronizer chain.
// A level change on din is accepted only after din has differed from the
// accepted level for DEBOUNCE_CYCLES consecutive cycles; any return to the
// accepted level clears the count.
//
// dout is the *next* accepted level (combinational from the internal
// registers), so the parent can register both the level and a same-cycle
// transition pulse from it. The internal level flop mirrors the parent's
// output register exactly.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   din    : synchronized level (chain output)
//   dout   : accepted level for the coming cycle
module ff_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level;
  logic          accept;

  // The D-th consecutive differing cycle is the one where cnt already
  // holds D-1; the change is taken on that edge.
  assign accept = (din != level) && (cnt == LAST);
  assign dout   = accept ? din : level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      level <= dout;
      if ((din == level) || accept)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + CW'(1);   // saturates below LAST; never wraps
    end
  end

endmodule

// File: rtl/ff_sync_bus.sv
// Multi-channel clock-domain synchronizer with edge-qualified pulses.
// Each channel runs through a STAGES-deep flop chain; the final flop is the
// sync_level register. sync_pulse is registered alongside it so the pulse
// coincides with the level change. any_pulse is the OR of sync_pulse,
// registered one cycle later.
//
// Optional feature: define FF_SYNC_DEBOUNCE_EN (with DEBOUNCE_CYCLES > 0) to
// insert a per-channel ff_sync_debounce filter after the full chain. Without
// the macro DEBOUNCE_CYCLES has no effect and no counters exist.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   signal     : [WIDTH] asynchronous channel inputs
//   sync_level : [WIDTH] synchronized (optionally debounced) levels
//   sync_pulse : [WIDTH] one-cycle pulse on a qualified level change
//   any_pulse  : OR of sync_pulse, one cycle later
module ff_sync_bus import params_pkg::*; #(
  parameter int         WIDTH           = 1,
  parameter int         STAGES          = 2,
  parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
  parameter int         DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] sync_level,
  output logic [WIDTH-1:0] sync_pulse,
  output logic             any_pulse
);

  if (STAGES < 2) begin : g_bad_stages
    $error("ff_sync_bus: STAGES must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("ff_sync_bus: WIDTH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 0) begin : g_bad_debounce
    $error("ff_sync_bus: DEBOUNCE_CYCLES must be >= 0");
  end

`ifdef FF_SYNC_DEBOUNCE_EN
  localparam bit DB_ON = (DEBOUNCE_CYCLES > 0);
`else
  localparam bit DB_ON = 1'b0;
`endif

  // With debounce the whole STAGES chain sits in front of the filter and
  // sync_level is an extra register; otherwise sync_level is the last
  // chain flop, so only STAGES-1 flops live in the chain array.
  localparam int CHAIN = DB_ON ? STAGES : STAGES - 1;

  logic [CHAIN-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]            level_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain[0] <= signal;
      for (int k = 1; k < CHAIN; k++)
        chain[k] <= chain[k-1];
    end
  end

`ifdef FF_SYNC_DEBOUNCE_EN
  if (DEBOUNCE_CYCLES > 0) begin : g_db
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      ff_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .reset(reset),
        .din  (chain[CHAIN-1][i]),
        .dout (level_nxt[i])
      );
    end
  end else begin : g_nodb
    assign level_nxt = chain[CHAIN-1];
  end
`else
  assign level_nxt = chain[CHAIN-1];
`endif

  // Output stage: level and its transition pulse update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_level <= '0;
      sync_pulse <= '0;
      any_pulse  <= 1'b0;
    end else begin
      sync_level <= level_nxt;
      for (int i = 0; i < WIDTH; i++)
        sync_pulse[i] <= edge_hit(EDGE_MODE, sync_level[i], level_nxt[i]);
      any_pulse <= |sync_pulse;
    end
  end

endmodule

// File: tb/tb_ff_sync_bus.sv
// Directed bench for ff_sync_bus. Four instances cover: WIDTH=1/STAGES=2
// rising edges, WIDTH=4/STAGES=3 both edges, falling-edge mode, and a
// DEBOUNCE_CYCLES=4 channel whose latency depends on FF_SYNC_DEBOUNCE_EN.
// DUMP_FILE_NAME names the waveform file a wrapper may use.
`timescale 1ns/1ps
module tb_ff_sync_bus;
  import params_pkg::*;

  parameter string DUMP_FILE_NAME = "tb_ff_sync_bus.vcd";

`ifdef FF_SYNC_DEBOUNCE_EN
  localparam int LAT_D = 5;   // STAGES-1+DEBOUNCE_CYCLES
`else
  localparam int LAT_D = 1;   // STAGES-1, debounce ignored
`endif

  logic clk = 1'b0;
  logic reset;
  logic       sig_a, sig_c, sig_d;
  logic [3:0] sig_b;
  logic       lvl_a, pul_a, any_a;
  logic [3:0] lvl_b, pul_b;
  logic       any_b;
  logic       lvl_c, pul_c, any_c;
  logic       lvl_d, pul_d, any_d;

  int checks = 0;
  int errors = 0;
  int pc_b1 = 0, pc_b3 = 0, pc_b02 = 0, pc_c = 0, pc_d = 0;

  always #(SIM_HALF_PERIOD_NS) clk = ~clk;

  ff_sync_bus #(.WIDTH(1), .STAGES(2), .EDGE_MODE(EDGE_RISE), .DEBOUNCE_CYCLES(0))
    u_a (.clk(clk), .reset(reset), .signal(sig_a), .sync_level(lvl_a),
         .sync_pulse(pul_a), .any_pulse(any_a));
  ff_sync_bus #(.WIDTH(4), .STAGES(3), .EDGE_MODE(EDGE_BOTH), .DEBOUNCE_CYCLES(0))
    u_b (.clk(clk), .reset(reset), .signal(sig_b), .sync_level(lvl_b),
         .sync_pulse(pul_b), .any_pulse(any_b));
  ff_sync_bus #(.WIDTH(1), .STAGES(2), .EDGE_MODE(EDGE_FALL), .DEBOUNCE_CYCLES(0))
    u_c (.clk(clk), .reset(reset), .signal(sig_c), .sync_level(lvl_c),
         .sync_pulse(pul_c), .any_pulse(any_c));
  ff_sync_bus #(.WIDTH(1), .STAGES(2), .EDGE_MODE(EDGE_RISE), .DEBOUNCE_CYCLES(4))
    u_d (.clk(clk), .reset(reset), .signal(sig_d), .sync_level(lvl_d),
         .sync_pulse(pul_d), .any_pulse(any_d));

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (pul_b[1]) pc_b1++;
    if (pul_b[3]) pc_b3++;
    if (pul_b[0] || pul_b[2]) pc_b02++;
    if (pul_c) pc_c++;
    if (pul_d) pc_d++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    $display("tb_ff_sync_bus: waveform file name %s", DUMP_FILE_NAME);
    reset = 1'b0;
    sig_a = 1'b0; sig_b = 4'b0000; sig_c = 1'b0; sig_d = 1'b0;

    // Reset state
    tick(2);
    chk1("rst_lvl_a", lvl_a, 1'b0);
    chk1("rst_pul_a", pul_a, 1'b0);
    chk1("rst_any_a", any_a, 1'b0);
    chk4("rst_lvl_b", lvl_b, 4'b0000);
    chk4("rst_pul_b", pul_b, 4'b0000);
    chk1("rst_lvl_d", lvl_d, 1'b0);
    reset = 1'b1;
    tick(2);

    // Rising edge, STAGES=2: sampled at edge N, level at N+1
    sig_a = 1'b1;
    tick(1);
    chk1("a_lvl_n", lvl_a, 1'b0);
    tick(1);
    chk1("a_lvl_n1", lvl_a, 1'b1);
    chk1("a_pul_n1", pul_a, 1'b1);
    chk1("a_any_n1", any_a, 1'b0);
    tick(1);
    chk1("a_pul_n2", pul_a, 1'b0);
    chk1("a_any_n2", any_a, 1'b1);
    tick(1);
    chk1("a_any_n3", any_a, 1'b0);
    sig_a = 1'b0;
    tick(2);
    chk1("a_fall_lvl", lvl_a, 1'b0);
    chk1("a_fall_nopul", pul_a, 1'b0);
    tick(1);
    chk1("a_fall_noany", any_a, 1'b0);

    // Both edges, WIDTH=4, STAGES=3
    sig_b = 4'b1010;
    tick(2);
    chk4("b_lvl_early", lvl_b, 4'b0000);
    tick(1);
    chk4("b_lvl_rise", lvl_b, 4'b1010);
    chk4("b_pul_rise", pul_b, 4'b1010);
    chk1("b_any_rise0", any_b, 1'b0);
    tick(1);
    chk4("b_pul_rise_end", pul_b, 4'b0000);
    chk1("b_any_rise1", any_b, 1'b1);
    tick(6);
    sig_b = 4'b0000;
    tick(2);
    chk4("b_lvl_hold", lvl_b, 4'b1010);
    chk4("b_pul_hold", pul_b, 4'b0000);
    tick(1);
    chk4("b_lvl_fall", lvl_b, 4'b0000);
    chk4("b_pul_fall", pul_b, 4'b1010);
    tick(1);
    chk4("b_pul_fall_end", pul_b, 4'b0000);
    chk1("b_any_fall", any_b, 1'b1);
    chkn("b_cnt_bit1", pc_b1, 2);
    chkn("b_cnt_bit3", pc_b3, 2);
    chkn("b_cnt_bit02", pc_b02, 0);

    // Falling-edge mode: 0->1->0 gives one pulse on the fall only
    sig_c = 1'b1;
    tick(3);
    chk1("c_lvl_hi", lvl_c, 1'b1);
    chk1("c_nopul_rise", pul_c, 1'b0);
    tick(3);
    sig_c = 1'b0;
    tick(1);
    chk1("c_lvl_still_hi", lvl_c, 1'b1);
    tick(1);
    chk1("c_lvl_lo", lvl_c, 1'b0);
    chk1("c_pul_fall", pul_c, 1'b1);
    tick(1);
    chk1("c_pul_end", pul_c, 1'b0);
    chk1("c_any", any_c, 1'b1);
    chkn("c_cnt", pc_c, 1);

    // DEBOUNCE_CYCLES=4 channel: latency LAT_D after the sampling edge
    sig_d = 1'b1;
    tick(LAT_D);
    chk1("d_lvl_before", lvl_d, 1'b0);
    tick(1);
    chk1("d_lvl_after", lvl_d, 1'b1);
    chk1("d_pul", pul_d, 1'b1);
    tick(1);
    chk1("d_pul_end", pul_d, 1'b0);
    chk1("d_any", any_d, 1'b1);
    sig_d = 1'b0;
    tick(LAT_D + 1);
    chk1("d_lvl_lo", lvl_d, 1'b0);
    tick(2);
    chkn("d_cnt", pc_d, 1);

`ifdef FF_SYNC_DEBOUNCE_EN
    // Glitch of 3 sampled cycles is rejected
    sig_d = 1'b1;
    tick(3);
    sig_d = 1'b0;
    tick(8);
    chk1("d_glitch_lvl", lvl_d, 1'b0);
    chkn("d_glitch_cnt", pc_d, 1);
`endif

    // Reset mid-operation: pulse in flight and debounce count both abort
    sig_a = 1'b1;
    sig_d = 1'b1;
    tick(2);
    chk1("r_pul_a_pre", pul_a, 1'b1);
    reset = 1'b0;
    #1;
    chk1("r_pul_a_async", pul_a, 1'b0);
    chk1("r_lvl_a_async", lvl_a, 1'b0);
    chk1("r_lvl_d_async", lvl_d, 1'b0);
    chk1("r_pul_d_async", pul_d, 1'b0);
    tick(2);
    chk1("r_lvl_a_held", lvl_a, 1'b0);
    chk1("r_any_a_held", any_a, 1'b0);
    chk1("r_lvl_d_held", lvl_d, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      if (k == 1) chk1("r_lvl_a_n", lvl_a, 1'b0);
      if (k == 2) begin
        chk1("r_lvl_a_n1", lvl_a, 1'b1);
        chk1("r_pul_a_n1", pul_a, 1'b1);
      end
      if (k == LAT_D) chk1("r_lvl_d_before", lvl_d, 1'b0);
      if (k == LAT_D + 1) begin
        chk1("r_lvl_d_after", lvl_d, 1'b1);
        chk1("r_pul_d_after", pul_d, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_sync_bus.md
FF_SYNC_BUS -- requirements
Module: ff_sync_bus

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels (>=1).
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel (>=2; elaboration error otherwise).
REQ-003 Parameter EDGE_MODE, default params_pkg::EDGE_RISE: pulse qualification (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-004 Parameter DEBOUNCE_CYCLES, default 0: stable-cycle count required before a level change is accepted; 0 means bypass.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 signal  input  WIDTH  asynchronous channel inputs.
REQ-008 sync_level  output  WIDTH  synchronized, optionally debounced, level per channel.
REQ-009 sync_pulse  output  WIDTH  one-cycle pulse per channel on a qualified sync_level transition.
REQ-010 any_pulse  output  1  registered OR of all sync_pulse bits, delayed one cycle.

Function
REQ-011 Each channel SHALL pass through a STAGES-deep flop chain; no logic between chain flops.
REQ-012 Without debounce, a change on signal[i] sampled at edge N SHALL appear on sync_level[i] immediately after edge N+STAGES-1.
REQ-013 sync_pulse[i] SHALL be registered, high for exactly one cycle, asserted in the same cycle sync_level[i] changes, and only if the change matches EDGE_MODE.
REQ-014 EDGE_BOTH SHALL pulse on both directions; back-to-back opposite transitions yield two separate one-cycle pulses.
REQ-015 Channels SHALL be fully independent; simultaneous transitions on several channels produce simultaneous pulses.
REQ-016 any_pulse SHALL be high in cycle C+1 when any sync_pulse bit is high in cycle C.
REQ-017 Input pulses shorter than one clock period MAY be lost; no pulse stretching is performed.

Reset
REQ-018 While reset is low: all chain flops, sync_level, sync_pulse, any_pulse and debounce counters SHALL be 0, asynchronously.
REQ-019 Reset assertion mid-operation SHALL abort any pending debounce count and suppress any pulse in flight.
REQ-020 After release with signal[i] high, channel i SHALL behave as a 0->1 transition (rising pulse after the normal latency).

Configuration
REQ-021 Macro FF_SYNC_DEBOUNCE_EN: when defined, and DEBOUNCE_CYCLES>0, per-channel debounce is compiled in.
REQ-022 With debounce: sync_level[i] SHALL change only after the chain output has differed from sync_level[i] for DEBOUNCE_CYCLES consecutive cycles; any return to sync_level[i] clears the counter to 0.
REQ-023 With debounce: total latency SHALL be STAGES-1+DEBOUNCE_CYCLES edges after the sampling edge; counter width $clog2(DEBOUNCE_CYCLES+1), saturating, never wrapping.
REQ-024 Without the macro: DEBOUNCE_CYCLES SHALL be ignored, no counters synthesized, behaviour per REQ-012.

Structure
REQ-025 edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH) SHALL live in params_pkg alongside SIM_HALF_PERIOD_NS.
REQ-026 Per-channel debounce SHALL be a sub-module ff_sync_debounce (ports clk, reset, din, dout), generated WIDTH times under the macro.
REQ-027 Bench tb_ff_sync_bus SHALL use params_pkg::SIM_HALF_PERIOD_NS for the clock and honour DUMP_FILE_NAME.

Verification
REQ-028 WIDTH=1, STAGES=2, EDGE_RISE: signal 0->1 before edge 5 -> sync_level=1 after edge 6, sync_pulse high one cycle, any_pulse high the following cycle.
REQ-029 WIDTH=4, STAGES=3, EDGE_BOTH: signal 4'b0000->4'b1010 then ->4'b0000 ten cycles later -> pulses on bits 1,3 at both transitions, bits 0,2 never pulse.
REQ-030 EDGE_FALL: 0->1->0 on channel 0 -> exactly one pulse, on the 1->0 transition only.
REQ-031 FF_SYNC_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, STAGES=2: high held 3 cycles then low -> no change; high held 6 cycles -> sync_level=1 after edge N+5, one pulse.
REQ-032 Reset low for 2 cycles during a debounce count with signal=1 -> outputs 0 during reset; after release full latency restarts, one rising pulse.
REQ-033 Without macro, DEBOUNCE_CYCLES=4 -> latency identical to REQ-028.
